// File: rtl/nand_sched_pkg.sv
// Shared constants for the NAND op scheduler and the bus engine it drives.
package nand_sched_pkg;

  localparam logic [1:0] OP_ERASE   = 2'b00;
  localparam logic [1:0] OP_PROGRAM = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [2:0] ST_GAP    = 3'd0;
  localparam logic [2:0] ST_ARB    = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  localparam int STATUS_FAIL_BIT = 0;

  // Only erase/program report pass/fail through the 70h status byte.
  function automatic logic op_has_status(input logic [1:0] op);
    return (op == OP_ERASE) || (op == OP_PROGRAM);
  endfunction

endpackage

// File: rtl/nand_op_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after i_ptr, wrapping. Pure combinational.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = (int'(i_ptr) + i) % N_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/nand_op_scheduler.sv
// Shares one NAND bus engine among N_REQ requesters: round-robin, inter-op gap, R/B wait.
// Optional WAIT timeout with engine abort: define NAND_SCHED_TIMEOUT_EN.
module nand_op_scheduler
  import nand_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [16*N_REQ-1:0]   req_row,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  fail,
  output logic                  eng_start,
  output logic [1:0]            eng_op,
  output logic [15:0]           eng_row,
  input  logic                  eng_done,
  input  logic [7:0]            eng_status,
  input  logic                  rb,
  output logic                  eng_abort
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [2:0]       r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_idx;
  logic [GW-1:0]    r_gap_cnt;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_fail;
  logic             r_fail_pend;
  logic [1:0]       r_op;
  logic [15:0]      r_row;

  logic [N_REQ-1:0]             w_gnt;
  logic [IW-1:0]                w_idx;
  logic                         w_any;
  logic [N_REQ-1:0][1:0]        w_op_arr;
  logic [N_REQ-1:0][15:0]       w_row_arr;
  logic                         w_timeout;
  logic                         w_unused;

  assign w_op_arr  = req_op;
  assign w_row_arr = req_row;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

`ifdef NAND_SCHED_TIMEOUT_EN
  logic [15:0] r_wcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_wcnt <= '0;
    else if (r_state == ST_ISSUE) r_wcnt <= '0;
    else if (r_state == ST_WAIT)  r_wcnt <= r_wcnt + 16'd1;
  end

  // A completion landing on the expiry cycle takes priority over the abort.
  assign w_timeout = (r_state == ST_WAIT) && !eng_done &&
                     (r_wcnt == 16'(TIMEOUT_CYCLES - 1));
  assign w_unused  = ^eng_status[7:1];
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^{eng_status[7:1], 16'(TIMEOUT_CYCLES)};
`endif

  assign eng_abort = w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_GAP;
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_gap_cnt   <= GW'(GAP_CYCLES);
      r_grant     <= '0;
      r_done      <= '0;
      r_fail      <= 1'b0;
      r_fail_pend <= 1'b0;
      r_op        <= '0;
      r_row       <= '0;
    end else begin
      r_done <= '0;
      r_fail <= 1'b0;
      case (r_state)
        ST_GAP: begin
          if (r_gap_cnt != '0)     r_gap_cnt <= r_gap_cnt - 1'b1;
          else if (rb && (|req))   r_state   <= ST_ARB;
        end
        ST_ARB: begin
          // Requester may have dropped in the single ARB cycle; just go back.
          if (w_any) begin
            r_grant <= w_gnt;
            r_idx   <= w_idx;
            r_op    <= w_op_arr[w_idx];
            r_row   <= w_row_arr[w_idx];
            if (w_op_arr[w_idx] == OP_ILLEGAL) begin
              r_fail_pend <= 1'b1;
              r_state     <= ST_REPORT;
            end else begin
              r_fail_pend <= 1'b0;
              r_state     <= ST_ISSUE;
            end
          end else begin
            r_state <= ST_GAP;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (eng_done) begin
            r_fail_pend <= op_has_status(r_op) && eng_status[STATUS_FAIL_BIT];
            r_state     <= ST_REPORT;
          end else if (w_timeout) begin
            r_fail_pend <= 1'b1;
            r_state     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          r_done    <= r_grant;
          r_fail    <= r_fail_pend;
          r_grant   <= '0;
          r_rr_ptr  <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
          r_gap_cnt <= GW'(GAP_CYCLES);
          r_state   <= ST_GAP;
        end
        default: r_state <= ST_GAP;
      endcase
    end
  end

  // Grant is visible during the ARB cycle itself, then held until the done pulse.
  assign grant     = (r_state == ST_ARB) ? w_gnt : r_grant;
  assign done      = r_done;
  assign fail      = r_fail;
  assign eng_start = (r_state == ST_ISSUE);
  assign eng_op    = r_op;
  assign eng_row   = r_row;

endmodule

// File: tb/tb_nand_op_scheduler.sv
// Directed self-checking bench for nand_op_scheduler (N_REQ=4, short gap, 16-cycle timeout).
module tb_nand_op_scheduler;

  localparam int N = 4;
  localparam int G = 8;
  localparam int T = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [16*N-1:0] req_row = '0;
  logic [N-1:0]    grant, done;
  logic            fail, eng_start, eng_abort;
  logic [1:0]      eng_op;
  logic [15:0]     eng_row;
  logic            eng_done = 1'b0;
  logic [7:0]      eng_status = '0;
  logic            rb = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;

  nand_op_scheduler #(.N_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_row(req_row),
    .grant(grant), .done(done), .fail(fail), .eng_start(eng_start),
    .eng_op(eng_op), .eng_row(eng_row), .eng_done(eng_done),
    .eng_status(eng_status), .rb(rb), .eng_abort(eng_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) n_start <= n_start + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_start(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (eng_start) begin ok = 1'b1; break; end
    end
    chk({tag, "_start_seen"}, 32'(ok), 32'd1);
  endtask

  // Called in the ISSUE cycle: answer eng_done on the first WAIT clock.
  task automatic complete(input logic [7:0] st, input logic [N-1:0] exp_done,
                          input logic exp_fail, input string tag);
    tick();
    chk({tag, "_start_1cyc"}, 32'(eng_start), 32'd0);
    eng_done = 1'b1; eng_status = st;
    tick();
    eng_done = 1'b0;
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_fail"}, 32'(fail), 32'(exp_fail));
    chk({tag, "_grant_clr"}, 32'(grant), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, t, bad, s0;
    bit seen;

    // Reset state
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_op", 32'(eng_op), 32'd0);
    chk("rst_row", 32'(eng_row), 32'd0);
    chk("rst_abort", 32'(eng_abort), 32'd0);
    tick();
    rst = 1'b1;

    // 1: single ERASE from requester 0
    req = 4'b0001; req_op = 8'b00_00_00_00; req_row = 64'h0000_0000_0000_0012;
    wait_start("t1");
    chk("t1_op", 32'(eng_op), 32'd0);
    chk("t1_row", 32'(eng_row), 32'h0012);
    chk("t1_grant", 32'(grant), 32'b0001);
    complete(8'hE0, 4'b0001, 1'b0, "t1");
    req = '0;

    // 2: all four hold READ requests -> 0,1,2,3,0 with gap spacing
    do_reset();
    req = 4'b1111; req_op = 8'b10_10_10_10;
    req_row = 64'h0300_0200_0100_0050;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start("t2");
      t = cyc;
      chk("t2_grant", 32'(grant), 32'(1 << (k % 4)));
      if (k > 0) chk("t2_spacing", 32'((t - prev) >= G + 3), 32'd1);
      prev = t;
      complete(8'h00, 4'(1 << (k % 4)), 1'b0, "t2");
    end
    req = '0;

    // 3: PROGRAM failing status, READ ignoring status bit 0
    req = 4'b0010; req_op = 8'b00_00_01_00;
    wait_start("t3p");
    chk("t3p_op", 32'(eng_op), 32'd1);
    complete(8'hE1, 4'b0010, 1'b1, "t3p");
    req_op = 8'b00_00_10_00;
    wait_start("t3r");
    chk("t3r_op", 32'(eng_op), 32'd2);
    complete(8'h01, 4'b0010, 1'b0, "t3r");
    req = '0;

    // 4: illegal op -> done+fail two clocks after ARB, no start
    req = 4'b0100; req_op = 8'b00_11_00_00;
    s0 = n_start;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (grant != '0) begin seen = 1'b1; break; end
    end
    chk("t4_arb_seen", 32'(seen), 32'd1);
    chk("t4_grant", 32'(grant), 32'b0100);
    tick();
    chk("t4_done_early", 32'(done), 32'd0);
    tick();
    chk("t4_done", 32'(done), 32'b0100);
    chk("t4_fail", 32'(fail), 32'd1);
    chk("t4_grant_clr", 32'(grant), 32'd0);
    req = '0;
    repeat (3) tick();
    chk("t4_no_start", 32'(n_start), 32'(s0));

    // 5: rb low stalls; stray eng_done in GAP ignored; rb high -> grant next cycle
    rb = 1'b0; req = 4'b0001; req_op = 8'b00_00_00_10;
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      tick();
      eng_done = (k == 100); eng_status = 8'h01;
      if (grant != '0 || done != '0 || eng_start) bad++;
    end
    eng_done = 1'b0;
    chk("t5_stall", 32'(bad), 32'd0);
    rb = 1'b1;
    tick();
    chk("t5_grant", 32'(grant), 32'b0001);
    wait_start("t5");
    complete(8'h00, 4'b0001, 1'b0, "t5");

    // 6: ERASE with eng_done withheld, then async reset in WAIT
    req = 4'b0001; req_op = 8'b00_00_00_00; req_row = 64'h0000_0000_0000_BEEF;
    wait_start("t6");
    tick();
`ifdef NAND_SCHED_TIMEOUT_EN
    t = 0;
    for (int w = 1; w <= 40; w++) begin
      if (eng_abort) begin t = w; break; end
      tick();
    end
    chk("t6_abort_clk", 32'(t), 32'(T));
    tick();
    tick();
    chk("t6_to_done", 32'(done), 32'b0001);
    chk("t6_to_fail", 32'(fail), 32'd1);
    wait_start("t6b");
    tick();
`else
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (eng_abort || done != '0) bad++;
      tick();
    end
    chk("t6_no_abort", 32'(bad), 32'd0);
    chk("t6_still_grant", 32'(grant), 32'b0001);
`endif
    chk("t6_row_held", 32'(eng_row), 32'hBEEF);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_op", 32'(eng_op), 32'd0);
    chk("t6_rst_row", 32'(eng_row), 32'd0);
    chk("t6_rst_start", 32'(eng_start), 32'd0);
    chk("t6_rst_abort", 32'(eng_abort), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_fail", 32'(fail), 32'd0);
    repeat (2) tick();
    chk("t6_rst_hold", 32'(grant), 32'd0);
    rst = 1'b1; req = '0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
